wb_commit_unit: RTL and testbench

Writeback/commit stage at the consumer end of the EX/WB pipeline buffer. Takes the buffered WB control and data fields, selects the register write-back value, and drives the register-file write port. Resolves branch and jump decisions, then redirects the PC. Squashes younger in-flight instructions for a fixed flush window through a small state machine.

---
 rtl/wb_pkg.sv | 7 +
 rtl/wb_flush_ctrl.sv | 34 +++
 rtl/wb_commit_unit.sv | 75 +++++++
 tb/tb_wb_commit_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback/commit stage
package wb_pkg;
    typedef enum logic {RUN, FLUSH} state_t;
    localparam logic BTYPE_ZERO  = 1'b0;
    localparam logic BTYPE_NEG   = 1'b1;
    localparam int   FLUSH_CNT_W = 4;
endpackage

// File: rtl/wb_flush_ctrl.sv
// wb_flush_ctrl: squashes the FLUSH_DEPTH instructions that follow a redirect
module wb_flush_ctrl
    import wb_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic redirect,
    output logic squash,
    output logic out_flush
);
    state_t                 state, state_n;
    logic [FLUSH_CNT_W-1:0] cnt, cnt_n;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= '0;
            out_flush <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            out_flush <= (state_n == FLUSH);
        end
    end
    // the last squashed slot is the one seen while the counter still reads 1
    always_comb begin
        state_n = (state == RUN) ? (redirect ? FLUSH : RUN)
                                 : ((cnt == FLUSH_CNT_W'(1)) ? RUN : FLUSH);
        cnt_n   = (state == RUN) ? (redirect ? FLUSH_CNT_W'(FLUSH_DEPTH) : cnt)
                                 : cnt - 1'b1;
    end
    assign squash = (state == FLUSH);
endmodule

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: write-back mux, branch resolve and PC redirect; WB_PERF_CNT_EN adds retire/taken counters
module wb_commit_unit
    import wb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int RD_W        = 6,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_ctrl_regwrt,
    input  logic              in_ctrl_branch,
    input  logic              in_ctrl_btype,
    input  logic              in_ctrl_jump,
    input  logic              in_ctrl_memtoreg,
    input  logic              in_ctrl_neg,
    input  logic              in_ctrl_zero,
    input  logic [DATA_W-1:0] in_memdata,
    input  logic [DATA_W-1:0] in_aluresult,
    input  logic [DATA_W-1:0] in_target,
    input  logic [RD_W-1:0]   in_rd,
`ifdef WB_PERF_CNT_EN
    output logic [31:0]       out_retired_cnt,
    output logic [31:0]       out_taken_cnt,
`endif
    output logic              out_rf_we,
    output logic [RD_W-1:0]   out_rf_waddr,
    output logic [DATA_W-1:0] out_rf_wdata,
    output logic              out_pc_sel,
    output logic [DATA_W-1:0] out_pc_target,
    output logic              out_flush
);
    logic squash, accept, taken, redirect;
    always_comb begin
        taken    = in_ctrl_jump | (in_ctrl_branch &
                   ((in_ctrl_btype == BTYPE_NEG) ? in_ctrl_neg : in_ctrl_zero));
        accept   = in_valid & ~squash;
        redirect = accept & taken;
    end
    wb_flush_ctrl #(.FLUSH_DEPTH(FLUSH_DEPTH)) u_flush (
        .clk       (clk),
        .rst       (rst),
        .redirect  (redirect),
        .squash    (squash),
        .out_flush (out_flush)
    );
    // a redirecting instruction still writes rd, which gives jump-and-link
    always_ff @(posedge clk) begin
        if (rst) begin
            out_rf_we     <= 1'b0;
            out_rf_waddr  <= '0;
            out_rf_wdata  <= '0;
            out_pc_sel    <= 1'b0;
            out_pc_target <= '0;
        end else begin
            out_rf_we     <= accept & in_ctrl_regwrt;
            out_rf_waddr  <= in_rd;
            out_rf_wdata  <= in_ctrl_memtoreg ? in_memdata : in_aluresult;
            out_pc_sel    <= redirect;
            out_pc_target <= redirect ? in_target : out_pc_target;
        end
    end
`ifdef WB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_retired_cnt <= '0;
            out_taken_cnt   <= '0;
        end else begin
            out_retired_cnt <= out_retired_cnt + 32'(accept);
            out_taken_cnt   <= out_taken_cnt + 32'(redirect);
        end
    end
`endif
endmodule

// File: tb/tb_wb_commit_unit.sv
// tb_wb_commit_unit: random and directed checks against a remaining-squash-slots model
module tb_wb_commit_unit;
    localparam int DATA_W = 32;
    localparam int RD_W   = 6;
    localparam int D      = 2;

    logic clk = 1'b0, rst = 1'b1;
    logic valid = 0, regwrt = 0, branch = 0, btype = 0, jump = 0, m2r = 0, neg = 0, zero = 0;
    logic [DATA_W-1:0] mem = '0, alu = '0, tgt = '0;
    logic [RD_W-1:0]   rd = '0;
    logic              rf_we, pc_sel, flush;
    logic [RD_W-1:0]   rf_waddr;
    logic [DATA_W-1:0] rf_wdata, pc_target;
`ifdef WB_PERF_CNT_EN
    logic [31:0] ret_cnt, tak_cnt;
`endif

    int total = 0, bad = 0;
    int m_left = 0;
    logic              m_we = 0, m_pcsel = 0, m_flush = 0;
    logic [RD_W-1:0]   m_waddr = '0;
    logic [DATA_W-1:0] m_wdata = '0, m_tgt = '0;
    logic [31:0]       m_ret = '0, m_tak = '0;

    always #5 clk = ~clk;

    wb_commit_unit #(.DATA_W(DATA_W), .RD_W(RD_W), .FLUSH_DEPTH(D)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (valid),
        .in_ctrl_regwrt   (regwrt),
        .in_ctrl_branch   (branch),
        .in_ctrl_btype    (btype),
        .in_ctrl_jump     (jump),
        .in_ctrl_memtoreg (m2r),
        .in_ctrl_neg      (neg),
        .in_ctrl_zero     (zero),
        .in_memdata       (mem),
        .in_aluresult     (alu),
        .in_target        (tgt),
        .in_rd            (rd),
`ifdef WB_PERF_CNT_EN
        .out_retired_cnt  (ret_cnt),
        .out_taken_cnt    (tak_cnt),
`endif
        .out_rf_we        (rf_we),
        .out_rf_waddr     (rf_waddr),
        .out_rf_wdata     (rf_wdata),
        .out_pc_sel       (pc_sel),
        .out_pc_target    (pc_target),
        .out_flush        (flush)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set(input logic v, input logic rw, input logic br, input logic bt,
                       input logic j, input logic mr, input logic n, input logic z,
                       input logic [DATA_W-1:0] md, input logic [DATA_W-1:0] ar,
                       input logic [DATA_W-1:0] t, input logic [RD_W-1:0] r);
        valid = v; regwrt = rw; branch = br; btype = bt; jump = j; m2r = mr;
        neg = n; zero = z; mem = md; alu = ar; tgt = t; rd = r;
    endtask

    task automatic idle();
        set(0, 0, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
    endtask

    // model: m_left counts how many upcoming slots are still squashed
    task automatic cycle();
        logic acc, tk;
        @(posedge clk);
        if (rst) begin
            m_left = 0; m_we = 0; m_waddr = '0; m_wdata = '0; m_pcsel = 0;
            m_tgt = '0; m_flush = 0; m_ret = '0; m_tak = '0;
        end else begin
            acc     = valid && (m_left == 0);
            tk      = jump || (branch && (btype ? neg : zero));
            m_we    = acc && regwrt;
            m_waddr = rd;
            m_wdata = m2r ? mem : alu;
            m_pcsel = acc && tk;
            if (acc && tk) begin
                m_tgt  = tgt;
                m_left = D;
                m_tak  = m_tak + 1;
            end else if (m_left > 0) begin
                m_left--;
            end
            if (acc) m_ret = m_ret + 1;
            m_flush = (m_left > 0);
        end
        #1;
        chk("rf_we", 64'(rf_we), 64'(m_we));
        chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
        chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        chk("pc_sel", 64'(pc_sel), 64'(m_pcsel));
        chk("pc_target", 64'(pc_target), 64'(m_tgt));
        chk("flush", 64'(flush), 64'(m_flush));
`ifdef WB_PERF_CNT_EN
        chk("retired_cnt", 64'(ret_cnt), 64'(m_ret));
        chk("taken_cnt", 64'(tak_cnt), 64'(m_tak));
`endif
    endtask

    initial begin
        rst = 1; idle();
        cycle(); cycle();
        rst = 0;
        cycle();
        // load then ALU op
        set(1, 1, 0, 0, 0, 1, 0, 0, 32'h0000_1234, 32'h0, 32'h0, 6'd5); cycle();
        set(1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFE, 32'h0, 6'd6); cycle();
        // BEQ taken followed by three writers
        set(1, 0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h40, 6'd0); cycle();
        chk("beq_pc_sel", 64'(pc_sel), 64'd1);
        for (int i = 0; i < 3; i++) begin
            set(1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'(100 + i), 32'h0, RD_W'(7 + i));
            cycle();
        end
        idle(); cycle();
        // branch on negative, not taken
        set(1, 0, 1, 1, 0, 0, 0, 1, 32'h0, 32'h0, 32'h99, 6'd0); cycle();
        set(1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h55, 32'h0, 6'd3); cycle();
        // jump-and-link, then a taken branch inside the flush window
        set(1, 1, 0, 0, 1, 0, 0, 0, 32'h0, 32'h1C, 32'h80, 6'd31); cycle();
        set(1, 1, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h100, 6'd1); cycle();
        idle(); cycle(); cycle(); cycle();
        // reset one cycle into the flush window, with a concurrent taken jump
        set(1, 1, 0, 0, 1, 0, 0, 0, 32'h0, 32'h7, 32'h200, 6'd2); cycle();
        rst = 1; cycle();
        rst = 0; idle(); cycle();
`ifdef WB_PERF_CNT_EN
        force dut.out_retired_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.out_retired_cnt;
        m_ret = 32'hFFFF_FFFF;
        set(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 6'd0); cycle();
        idle(); cycle();
`endif
        for (int i = 0; i < 2000; i++) begin
            set($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) == 0,
                1'($urandom), $urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom),
                1'($urandom), $urandom, $urandom, $urandom, RD_W'($urandom));
            rst = ($urandom_range(0, 49) == 0);
            cycle();
        end
        rst = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
